uart_sfr_bridge: RTL and testbench

- Upstream master of the SFR register bus: turns host command bytes from the UART receiver into single-cycle SFR bus write/read cycles.
- Read data (and write acknowledges) go back to the UART transmitter.
- Sits between the uart_rx/uart_tx byte interfaces and the shared 16-bit address / 8-bit tri-state data bus that all SFR registers hang on.
- Exactly one bus master per bus.

---
 rtl/uart_sfr_bridge.sv | 190 +++++++++++++++++++
 tb/tb_uart_sfr_bridge.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_sfr_bridge.sv
// uart_sfr_bridge: turns UART host command frames into single-cycle SFR bus
// write/read cycles and returns the read data or a write acknowledge byte to
// the UART transmitter. This is the only master on its SFR bus.
//
// Handshakes:
//   rx : i_rx_valid is a one-cycle strobe. No backpressure exists, so a byte
//        that arrives while a bus cycle or reply is in flight is dropped and
//        flagged on o_err.
//   tx : o_tx_valid/o_tx_data are held stable until a rising edge with
//        i_tx_ready=1. That edge completes the transfer.
//   bus: o_ad_set drives io_ad_data for exactly one cycle (write).
//        o_ad_enable asks the addressed SFR to drive io_ad_data for exactly
//        one cycle (read). The two strobes are never high together.
module uart_sfr_bridge #(
  parameter logic [7:0]  CMD_WRITE   = 8'h57,
  parameter logic [7:0]  CMD_READ    = 8'h52,
  parameter logic [7:0]  ACK_BYTE    = 8'h4B,
  parameter logic [23:0] TIMEOUT_CYC = 24'd1_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic [15:0] o_address,
  output logic        o_ad_set,
  output logic        o_ad_enable,
  inout  wire  [7:0]  io_ad_data,
  output logic        o_busy,
  output logic        o_err,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR_H = 3'd1,
    ADDR_L = 3'd2,
    DATA   = 3'd3,
    BUS_WR = 3'd4,
    BUS_RD = 3'd5,
    TX     = 3'd6
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        is_write;
  logic        is_write_next;
  logic [7:0]  wdata;
  logic [23:0] tmo_cnt;
  logic        err_next;
  logic        load_hi;
  logic        load_lo;
  logic        load_data;
  logic        waiting;
  logic        tmo_hit;

  assign dbg_state = state;

  // The bridge owns the data bus only during its registered write strobe.
  assign io_ad_data = o_ad_set ? wdata : 8'hzz;

  // The timeout counter only runs while a frame is partly received.
  assign waiting = (state == ADDR_H) || (state == ADDR_L) || (state == DATA);
  assign tmo_hit = waiting && (tmo_cnt == (TIMEOUT_CYC - 24'd1));

  // Next-state and per-cycle control decode.
  // If a byte and a timeout fall in the same cycle, the byte wins.
  always_comb begin
    state_next    = state;
    is_write_next = is_write;
    err_next      = 1'b0;
    load_hi       = 1'b0;
    load_lo       = 1'b0;
    load_data     = 1'b0;
    case (state)
      IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == CMD_WRITE) begin
            state_next    = ADDR_H;
            is_write_next = 1'b1;
          end else if (i_rx_data == CMD_READ) begin
            state_next    = ADDR_H;
            is_write_next = 1'b0;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      ADDR_H: begin
        if (i_rx_valid) begin
          load_hi    = 1'b1;
          state_next = ADDR_L;
        end else if (tmo_hit) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end
      end
      ADDR_L: begin
        if (i_rx_valid) begin
          load_lo    = 1'b1;
          state_next = is_write ? DATA : BUS_RD;
        end else if (tmo_hit) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end
      end
      DATA: begin
        if (i_rx_valid) begin
          load_data  = 1'b1;
          state_next = BUS_WR;
        end else if (tmo_hit) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end
      end
      BUS_WR: begin
        state_next = TX;
        err_next   = i_rx_valid;
      end
      BUS_RD: begin
        state_next = TX;
        err_next   = i_rx_valid;
      end
      TX: begin
        if (i_tx_ready) begin
          state_next = IDLE;
        end
        err_next = i_rx_valid;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, frame registers and registered outputs.
  // Strobes, busy and tx_valid come from the next state, so each one lines up
  // with the cycle the FSM spends in the matching state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      is_write    <= 1'b0;
      wdata       <= 8'h00;
      o_address   <= 16'h0000;
      o_tx_data   <= 8'h00;
      o_tx_valid  <= 1'b0;
      o_ad_set    <= 1'b0;
      o_ad_enable <= 1'b0;
      o_busy      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state    <= state_next;
      is_write <= is_write_next;
      if (load_hi) begin
        o_address[15:8] <= i_rx_data;
      end
      if (load_lo) begin
        o_address[7:0] <= i_rx_data;
      end
      if (load_data) begin
        wdata <= i_rx_data;
      end
      if (state == BUS_WR) begin
        o_tx_data <= ACK_BYTE;
      end else if (state == BUS_RD) begin
        o_tx_data <= io_ad_data;
      end
      o_tx_valid  <= (state_next == TX);
      o_ad_set    <= (state_next == BUS_WR);
      o_ad_enable <= (state_next == BUS_RD);
      o_busy      <= (state_next != IDLE);
      o_err       <= err_next;
    end
  end

  // Inter-byte idle counter. It restarts on every accepted byte and is held
  // at zero outside the frame-receive states.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tmo_cnt <= 24'd0;
    end else if (i_rx_valid || !waiting) begin
      tmo_cnt <= 24'd0;
    end else begin
      tmo_cnt <= tmo_cnt + 24'd1;
    end
  end

endmodule

// File: tb/tb_uart_sfr_bridge.sv
// Directed bench for uart_sfr_bridge. Two SFRs (16'h1234 and 16'h0001) hang on
// a pulled-down bus. Inputs change 1 time unit after the rising edge, and
// outputs are sampled on the falling edge.
module tb_uart_sfr_bridge;

  localparam logic [23:0] TMO = 24'd40;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] address;
  logic        ad_set;
  logic        ad_enable;
  logic        busy;
  logic        err;
  logic [2:0]  dbg_state;
  wire  [7:0]  ad_data;

  int checks;
  int errors;
  int err_cnt;
  int set_cnt;
  int both_cnt;
  int e0;
  int s0;

  logic [7:0] sfr_a;
  logic [7:0] sfr_b;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] e_b;
  logic [7:0] g_b;

  uart_sfr_bridge #(
    .CMD_WRITE  (8'h57),
    .CMD_READ   (8'h52),
    .ACK_BYTE   (8'h4B),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .i_tx_ready (tx_ready),
    .o_address  (address),
    .o_ad_set   (ad_set),
    .o_ad_enable(ad_enable),
    .io_ad_data (ad_data),
    .o_busy     (busy),
    .o_err      (err),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bus environment ----------------
  for (genvar g = 0; g < 8; g++) begin : g_pd
    pulldown pd (ad_data[g]);
  end

  assign ad_data = (ad_enable && address == 16'h1234) ? sfr_a :
                   (ad_enable && address == 16'h0001) ? sfr_b : 8'hzz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sfr_a <= 8'h00;
      sfr_b <= 8'h00;
    end else if (ad_set) begin
      if (address == 16'h1234) sfr_a <= ad_data;
      else if (address == 16'h0001) sfr_b <= ad_data;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (tx_valid && tx_ready) got_q.push_back(tx_data);
    if (err) err_cnt <= err_cnt + 1;
    if (ad_set) set_cnt <= set_cnt + 1;
    if (ad_set && ad_enable) both_cnt <= both_cnt + 1;
  end

  // ---------------- driver ----------------
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (address !== 16'h0000) begin errors++; $display("FAIL reset_address: got %h expected 0000", address); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    checks++; if ({tx_valid, ad_set, ad_enable, busy, err} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {tx_valid, ad_set, ad_enable, busy, err}); end
    checks++; if (ad_data !== 8'h00) begin errors++; $display("FAIL reset_bus: got %h expected 00 (pulled down)", ad_data); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (dbg_state !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL reset_idle: got state %0d busy %b expected 0 0", dbg_state, busy); end
  endtask

  task automatic test_write;
    tx_ready = 1'b1;
    send_byte(8'h57); send_byte(8'h12); send_byte(8'h34); send_byte(8'hA5);
    @(negedge clk);
    checks++; if (ad_set !== 1'b1 || ad_enable !== 1'b0) begin errors++; $display("FAIL write_strobe: got set %b en %b expected 1 0", ad_set, ad_enable); end
    checks++; if (ad_data !== 8'hA5) begin errors++; $display("FAIL write_bus_data: got %h expected a5", ad_data); end
    checks++; if (address !== 16'h1234) begin errors++; $display("FAIL write_address: got %h expected 1234", address); end
    @(negedge clk);
    checks++; if (ad_set !== 1'b0) begin errors++; $display("FAIL write_strobe_len: got %b expected 0", ad_set); end
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h4B) begin errors++; $display("FAIL write_ack: got valid %b data %h expected 1 4b", tx_valid, tx_data); end
    exp_q.push_back(8'h4B);
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL write_done: got valid %b busy %b expected 0 0", tx_valid, busy); end
    checks++; if (sfr_a !== 8'hA5) begin errors++; $display("FAIL write_sfr: got %h expected a5", sfr_a); end
  endtask

  task automatic test_read_held;
    tx_ready = 1'b0;
    send_byte(8'h52); send_byte(8'h12); send_byte(8'h34);
    @(negedge clk);
    checks++; if (ad_enable !== 1'b1 || ad_set !== 1'b0) begin errors++; $display("FAIL read_strobe: got en %b set %b expected 1 0", ad_enable, ad_set); end
    checks++; if (ad_data !== 8'hA5) begin errors++; $display("FAIL read_bus_data: got %h expected a5", ad_data); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin errors++; $display("FAIL read_hold_%0d: got valid %b data %h expected 1 a5", i, tx_valid, tx_data); end
    end
    exp_q.push_back(8'hA5);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    @(negedge clk);
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL read_before_accept: got %b expected 1", tx_valid); end
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL read_accept: got valid %b busy %b expected 0 0", tx_valid, busy); end
  endtask

  task automatic test_unmapped;
    s0 = set_cnt;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h99);
    @(negedge clk);
    checks++; if (ad_enable !== 1'b1 || ad_set !== 1'b0) begin errors++; $display("FAIL unmapped_strobe: got en %b set %b expected 1 0", ad_enable, ad_set); end
    checks++; if (address !== 16'h0099) begin errors++; $display("FAIL unmapped_address: got %h expected 0099", address); end
    checks++; if (ad_data !== 8'h00) begin errors++; $display("FAIL unmapped_bus: got %h expected 00", ad_data); end
    @(negedge clk);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin errors++; $display("FAIL unmapped_reply: got valid %b data %h expected 1 00", tx_valid, tx_data); end
    exp_q.push_back(8'h00);
    @(negedge clk);
    checks++; if (set_cnt !== s0) begin errors++; $display("FAIL unmapped_no_set: got %0d set cycles expected %0d", set_cnt, s0); end
  endtask

  task automatic test_stray;
    e0 = err_cnt;
    send_byte(8'h33);
    @(negedge clk);
    checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL stray_err: got err %b busy %b expected 1 0", err, busy); end
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL stray_err_len: got %b expected 0", err); end
    send_byte(8'h52); send_byte(8'h12); send_byte(8'h34);
    @(negedge clk);
    checks++; if (ad_enable !== 1'b1) begin errors++; $display("FAIL stray_read_strobe: got %b expected 1", ad_enable); end
    @(negedge clk);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin errors++; $display("FAIL stray_read_reply: got valid %b data %h expected 1 a5", tx_valid, tx_data); end
    exp_q.push_back(8'hA5);
    @(negedge clk);
    checks++; if (err_cnt !== e0 + 1) begin errors++; $display("FAIL stray_err_count: got %0d expected %0d", err_cnt, e0 + 1); end
  endtask

  task automatic test_timeout;
    e0 = err_cnt;
    s0 = set_cnt;
    send_byte(8'h57); send_byte(8'h12);
    repeat (int'(TMO) - 1) @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1 || dbg_state !== 3'd2 || err !== 1'b0) begin errors++; $display("FAIL timeout_early: got busy %b state %0d err %b expected 1 2 0", busy, dbg_state, err); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || dbg_state !== 3'd0 || err !== 1'b1) begin errors++; $display("FAIL timeout_fire: got busy %b state %0d err %b expected 0 0 1", busy, dbg_state, err); end
    checks++; if (address !== 16'h1234) begin errors++; $display("FAIL timeout_address_kept: got %h expected 1234", address); end
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL timeout_err_len: got %b expected 0", err); end
    checks++; if (set_cnt !== s0 || err_cnt !== e0 + 1) begin errors++; $display("FAIL timeout_counts: got set %0d err %0d expected %0d %0d", set_cnt, err_cnt, s0, e0 + 1); end
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h01); send_byte(8'h3C);
    @(negedge clk);
    checks++; if (ad_set !== 1'b1 || address !== 16'h0001 || ad_data !== 8'h3C) begin errors++; $display("FAIL timeout_next_write: got set %b addr %h data %h expected 1 0001 3c", ad_set, address, ad_data); end
    @(negedge clk);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h4B) begin errors++; $display("FAIL timeout_next_ack: got valid %b data %h expected 1 4b", tx_valid, tx_data); end
    exp_q.push_back(8'h4B);
    @(negedge clk);
    checks++; if (sfr_b !== 8'h3C) begin errors++; $display("FAIL timeout_next_sfr: got %h expected 3c", sfr_b); end
  endtask

  task automatic test_reset_midframe;
    s0 = set_cnt;
    send_byte(8'h57); send_byte(8'h12); send_byte(8'h34);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (address !== 16'h0000 || tx_data !== 8'h00) begin errors++; $display("FAIL midreset_regs: got addr %h tx %h expected 0000 00", address, tx_data); end
    checks++; if ({tx_valid, ad_set, ad_enable, busy, err} !== 5'b0 || dbg_state !== 3'd0) begin errors++; $display("FAIL midreset_flags: got %b state %0d expected 00000 0", {tx_valid, ad_set, ad_enable, busy, err}, dbg_state); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (set_cnt !== s0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_no_set: got set %0d busy %b expected %0d 0", set_cnt, busy, s0); end
    send_byte(8'h57); send_byte(8'h12); send_byte(8'h34); send_byte(8'hC3);
    @(negedge clk);
    checks++; if (ad_set !== 1'b1 || address !== 16'h1234 || ad_data !== 8'hC3) begin errors++; $display("FAIL midreset_next_write: got set %b addr %h data %h expected 1 1234 c3", ad_set, address, ad_data); end
    @(negedge clk);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h4B) begin errors++; $display("FAIL midreset_next_ack: got valid %b data %h expected 1 4b", tx_valid, tx_data); end
    exp_q.push_back(8'h4B);
    @(negedge clk);
    checks++; if (sfr_a !== 8'hC3) begin errors++; $display("FAIL midreset_sfr: got %h expected c3", sfr_a); end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    checks   = 0;
    errors   = 0;
    err_cnt  = 0;
    set_cnt  = 0;
    both_cnt = 0;
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;

    test_reset();
    test_write();
    test_read_held();
    test_unmapped();
    test_stray();
    test_timeout();
    test_reset_midframe();
    repeat (2) @(negedge clk);

    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL strobe_overlap: got %0d cycles expected 0", both_cnt); end
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL tx_count: got %0d bytes expected %0d", got_q.size(), exp_q.size());
    end else begin
      while (exp_q.size() > 0) begin
        e_b = exp_q.pop_front();
        g_b = got_q.pop_front();
        checks++; if (g_b !== e_b) begin errors++; $display("FAIL tx_byte: got %h expected %h", g_b, e_b); end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test expected finish within 10000 cycles");
    $fatal(1);
  end

endmodule
